// File: rtl/pc_gen_pkg.sv
// pc_gen shared types and defaults.
// Holds the fetch FSM state enum and parameter defaults.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } pc_state_e;

  localparam int unsigned PC_WIDTH      = 32;
  localparam int unsigned PC_INC        = 4;
  localparam int unsigned PC_ALIGN_BITS = 2;
  localparam int unsigned PC_CNT_W      = 16;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake between pc_gen and the instruction memory.
// The master side presents the PC; the slave side accepts it.
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) ();

  logic             fetch_valid;
  logic             fetch_ready;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             flush;

  modport master (
    output fetch_valid,
    output pc,
    output pc_plus,
    output flush,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  pc,
    input  pc_plus,
    input  flush,
    output fetch_ready
  );

endinterface

// File: rtl/pc_gen_next_mux.sv
// Next-PC selection for the fetch stage.
// Resolves trap > branch > misaligned branch > sequential fetch > hold.
module pc_gen_next_mux
  import pc_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = PC_WIDTH,
  parameter int unsigned INC        = PC_INC,
  parameter int unsigned ALIGN_BITS = PC_ALIGN_BITS
) (
  input  pc_state_e        state,
  input  logic [WIDTH-1:0] pc,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_tgt,
  input  logic             trap,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic             fire,
  output logic [WIDTH-1:0] next_pc,
  output logic             take_flush,
  output logic             go_fault
);

  // Zero mask when ALIGN_BITS is 0, which disables the check.
  localparam logic [WIDTH-1:0] LOW_MASK =
    WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [WIDTH-1:0] trap_pc;
  logic             tgt_bad;

  assign trap_pc = trap_vec & ~LOW_MASK;
  assign tgt_bad = |(branch_tgt & LOW_MASK);

  always_comb begin
    next_pc    = pc;
    take_flush = 1'b0;
    go_fault   = 1'b0;
    unique case (state)
      RUN: begin
        if (trap) begin
          next_pc    = trap_pc;
          take_flush = 1'b1;
        end else if (branch_taken && !tgt_bad) begin
          next_pc    = branch_tgt;
          take_flush = 1'b1;
        end else if (branch_taken) begin
          go_fault = 1'b1;
        end else if (fire) begin
          next_pc = pc + WIDTH'(INC);
        end
      end
      FAULT: begin
        if (trap) begin
          next_pc    = trap_pc;
          take_flush = 1'b1;
        end
      end
      default: begin
        next_pc = pc;
      end
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with boot bubble, redirects,
// misaligned-branch fault and accepted-fetch counter.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned      WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INC          = PC_INC,
  parameter int unsigned      ALIGN_BITS   = PC_ALIGN_BITS,
  parameter int unsigned      CNT_W        = PC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_tgt,
  input  logic             trap,
  input  logic [WIDTH-1:0] trap_vec,
  pc_gen_if.master         fif,
  output logic             misalign,
  output logic [WIDTH-1:0] badaddr,
  output logic [CNT_W-1:0] fetch_cnt
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] badaddr_q, badaddr_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] next_pc;
  logic             take_flush;
  logic             go_fault;
  logic             fire;

  assign fif.fetch_valid = rst && (state_q == RUN) && !stall;
  assign fif.pc          = pc_q;
  assign fif.pc_plus     = pc_q + WIDTH'(INC);
  assign fif.flush       = flush_q;
  assign fire            = fif.fetch_valid && fif.fetch_ready;
  assign misalign        = misalign_q;
  assign badaddr         = badaddr_q;
  assign fetch_cnt       = cnt_q;

  pc_gen_next_mux #(
    .WIDTH      (WIDTH),
    .INC        (INC),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_mux (
    .state        (state_q),
    .pc           (pc_q),
    .branch_taken (branch_taken),
    .branch_tgt   (branch_tgt),
    .trap         (trap),
    .trap_vec     (trap_vec),
    .fire         (fire),
    .next_pc      (next_pc),
    .take_flush   (take_flush),
    .go_fault     (go_fault)
  );

  // A fetch accepted alongside a redirect still counts.
  always_comb begin
    state_d    = state_q;
    pc_d       = next_pc;
    flush_d    = take_flush;
    badaddr_d  = badaddr_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q + CNT_W'(fire);
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (go_fault) begin
          state_d    = FAULT;
          misalign_d = 1'b1;
          badaddr_d  = branch_tgt;
        end
      end
      FAULT: begin
        if (trap) begin
          state_d    = RUN;
          misalign_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      badaddr_q  <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      badaddr_q  <= badaddr_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Randomised bench for pc_gen against a behavioural PC model.
// Directed scenarios first, then random redirects/stalls/resets.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_tgt;
  logic        trap;
  logic [31:0] trap_vec;
  logic        misalign;
  logic [31:0] badaddr;
  logic [15:0] fetch_cnt;

  pc_gen_if #(.WIDTH(32)) fif ();

  pc_gen #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h100),
    .INC          (4),
    .ALIGN_BITS   (2),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_tgt   (branch_tgt),
    .trap         (trap),
    .trap_vec     (trap_vec),
    .fif          (fif),
    .misalign     (misalign),
    .badaddr      (badaddr),
    .fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: mode 0=boot, 1=running, 2=faulted.
  localparam longint M32 = 64'h1_0000_0000;
  bit     m_known;
  int     m_mode;
  longint m_pc;
  longint m_bad;
  bit     m_flush;
  bit     m_mis;
  int     m_cnt;

  function automatic longint align4(input longint a);
    return a - (a % 4);
  endfunction

  task automatic model_edge();
    bit hs;
    if (!rst) begin
      m_known = 1;
      m_mode  = 0;
      m_pc    = 'h100;
      m_bad   = 0;
      m_flush = 0;
      m_mis   = 0;
      m_cnt   = 0;
    end else if (m_mode == 0) begin
      m_mode  = 1;
      m_flush = 0;
    end else if (m_mode == 1) begin
      hs = !stall && fif.fetch_ready;
      if (hs) m_cnt = (m_cnt + 1) % 65536;
      m_flush = 0;
      if (trap) begin
        m_pc    = align4(trap_vec);
        m_flush = 1;
      end else if (branch_taken && branch_tgt % 4 == 0) begin
        m_pc    = branch_tgt;
        m_flush = 1;
      end else if (branch_taken) begin
        m_bad  = branch_tgt;
        m_mis  = 1;
        m_mode = 2;
      end else if (hs) begin
        m_pc = (m_pc + 4) % M32;
      end
    end else begin
      m_flush = 0;
      if (trap) begin
        m_pc    = align4(trap_vec);
        m_mis   = 0;
        m_flush = 1;
        m_mode  = 1;
      end
    end
  endtask

  task automatic tick();
    #2;
    if (m_known) begin
      chk("fv", 32'(fif.fetch_valid),
          32'(rst && m_mode == 1 && !stall));
      chk("pc", fif.pc, 32'(m_pc));
      chk("pc_plus", fif.pc_plus, 32'((m_pc + 4) % M32));
      chk("flush", 32'(fif.flush), 32'(m_flush));
      chk("misalign", 32'(misalign), 32'(m_mis));
      chk("badaddr", badaddr, 32'(m_bad));
      chk("cnt", 32'(fetch_cnt), 32'(m_cnt));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    stall           = 0;
    branch_taken    = 0;
    trap            = 0;
    fif.fetch_ready = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_known = 0;
    rst = 0;
    branch_tgt = 0;
    trap_vec   = 0;
    idle();

    tick();
    tick();
    chk("t1_pc", fif.pc, 32'h100);
    chk("t1_fv_rst", 32'(fif.fetch_valid), 32'd0);
    rst = 1;
    tick();
    chk("t1_fv_run", 32'(fif.fetch_valid), 32'd1);

    fif.fetch_ready = 1;
    repeat (3) tick();
    chk("t2_pc", fif.pc, 32'h10C);
    chk("t2_cnt", 32'(fetch_cnt), 32'd3);
    fif.fetch_ready = 0;
    tick();
    chk("t2_hold", fif.pc, 32'h10C);

    trap = 1; trap_vec = 32'h80;
    branch_taken = 1; branch_tgt = 32'h200;
    stall = 1;
    tick();
    chk("t3_pc", fif.pc, 32'h80);
    chk("t3_flush", 32'(fif.flush), 32'd1);
    idle();
    tick();
    chk("t3_flush_low", 32'(fif.flush), 32'd0);

    branch_taken = 1; branch_tgt = 32'h202;
    tick();
    chk("t4_mis", 32'(misalign), 32'd1);
    chk("t4_bad", badaddr, 32'h202);
    chk("t4_fv", 32'(fif.fetch_valid), 32'd0);
    branch_tgt = 32'h300;
    tick();
    chk("t4_ign_pc", fif.pc, 32'h80);
    branch_taken = 0;
    trap = 1; trap_vec = 32'h43;
    tick();
    chk("t4_trap_pc", fif.pc, 32'h40);
    chk("t4_mis_clr", 32'(misalign), 32'd0);
    trap = 0;
    tick();
    chk("t4_run_fv", 32'(fif.fetch_valid), 32'd1);

    trap = 1; trap_vec = 32'hFFFF_FFFC;
    tick();
    trap = 0; fif.fetch_ready = 1;
    tick();
    chk("t5_wrap", fif.pc, 32'h0);
    fif.fetch_ready = 0;

    branch_taken = 1; branch_tgt = 32'h5;
    tick();
    chk("t5_fault", 32'(misalign), 32'd1);
    branch_taken = 0; rst = 0;
    tick();
    chk("t5_rst_pc", fif.pc, 32'h100);
    chk("t5_rst_mis", 32'(misalign), 32'd0);
    chk("t5_rst_bad", badaddr, 32'h0);
    rst = 1;
    tick();

    for (int i = 0; i < 500; i++) begin
      rst             = ($urandom_range(0, 39) != 0);
      stall           = ($urandom_range(0, 3) == 0);
      fif.fetch_ready = ($urandom_range(0, 1) == 1);
      branch_taken    = ($urandom_range(0, 5) == 0);
      branch_tgt      = $urandom;
      if ($urandom_range(0, 3) != 0) branch_tgt[1:0] = 2'b00;
      trap            = ($urandom_range(0, 11) == 0);
      trap_vec        = $urandom;
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
